// File: rtl/stage4_message_assemble_pkg.sv
// Shared constants, type codes and tag decode for the stage4 message assembler.
package stage4_message_assemble_pkg;

  localparam int unsigned DATA_W_DEF                = 64;
  localparam int unsigned MAX_MESSAGE_BITS          = 512;
  localparam int unsigned MESSAGE_MUX_CONTROL_WIDTH = 2;
  localparam int unsigned TIMEOUT_DEF               = 255;

  localparam logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] MESSAGE_MUX_NONE = 2'd0;
  localparam logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] MESSAGE_MUX_A    = 2'd1;
  localparam logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] MESSAGE_MUX_K    = 2'd2;

  localparam logic [7:0] TYPE_BYTE_A = 8'h61;
  localparam logic [7:0] TYPE_BYTE_K = 8'h6B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Message type from the first byte of a sop word.
  function automatic logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] tag_decode(input logic [7:0] type_byte);
    logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] tag;
    tag = MESSAGE_MUX_NONE;
    if (type_byte == TYPE_BYTE_A) tag = MESSAGE_MUX_A;
    else if (type_byte == TYPE_BYTE_K) tag = MESSAGE_MUX_K;
    return tag;
  endfunction

endpackage

// File: rtl/stage4_message_assemble_lane_buffer.sv
// One message lane: word-indexed payload register, type tag and overflow detect.
module stage4_lane_buffer
  import stage4_message_assemble_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MSG_BITS = MAX_MESSAGE_BITS,
  parameter int unsigned CTRL_W   = MESSAGE_MUX_CONTROL_WIDTH,
  parameter int unsigned IDX_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                start,
  input  logic                wr,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   data,
  output logic [MSG_BITS-1:0] payload,
  output logic [CTRL_W-1:0]   tag,
  output logic                trunc_c
);

  localparam int unsigned WORDS = MSG_BITS / DATA_W;

  // Only the first overflow word flags; later ones carry a saturated index.
  assign trunc_c = wr && (idx == IDX_W'(WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      payload <= '0;
      tag     <= CTRL_W'(MESSAGE_MUX_NONE);
    end else if (clr) begin
      payload <= '0;
      tag     <= CTRL_W'(MESSAGE_MUX_NONE);
    end else if (wr) begin
      if (start) begin
        payload                      <= '0;
        payload[MSG_BITS-1 -: DATA_W] <= data;
        tag                          <= CTRL_W'(tag_decode(data[DATA_W-1 -: 8]));
      end else begin
        for (int k = 1; k < int'(WORDS); k++) begin
          if (idx == IDX_W'(k)) payload[MSG_BITS-1-k*DATA_W -: DATA_W] <= data;
        end
      end
    end
  end

endmodule

// File: rtl/stage4_message_assemble.sv
// Packs a word stream of feed messages into three tagged lanes for stage5.
// Optional STAGE4_MSG_CNT_EN adds per-type message and truncation counters.
module stage4_message_assemble
  import stage4_message_assemble_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MSG_BITS = MAX_MESSAGE_BITS,
  parameter int unsigned CTRL_W   = MESSAGE_MUX_CONTROL_WIDTH,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_sop,
  input  logic                in_eop,
  input  logic                in_pkt_end,
  input  logic                out_ready,
  output logic                message_en,
  output logic [MSG_BITS-1:0] message_1,
  output logic [MSG_BITS-1:0] message_2,
  output logic [MSG_BITS-1:0] message_3,
  output logic [CTRL_W-1:0]   message_mux_control_m1,
  output logic [CTRL_W-1:0]   message_mux_control_m2,
  output logic [CTRL_W-1:0]   message_mux_control_m3,
  output logic                trunc_err
`ifdef STAGE4_MSG_CNT_EN
  ,
  output logic [31:0]         cnt_a,
  output logic [31:0]         cnt_k,
  output logic [31:0]         cnt_trunc
`endif
);

  localparam int unsigned WORDS = MSG_BITS / DATA_W;
  localparam int unsigned IDX_W = $clog2(WORDS + 2);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  state_t           state, state_d;
  logic [1:0]       lane_cnt, lane_cnt_d;
  logic [IDX_W-1:0] wcnt, wcnt_d, wr_idx;
  logic [TO_W-1:0]  to_cnt, to_cnt_d;
  logic [1:0]       wr_lane;
  logic             acc, start, wr, clr, close;
  logic [2:0]       trunc_c;

  assign acc = in_valid && in_ready;

  // lane_cnt counts closed lanes between messages and names the open lane in FILL.
  always_comb begin
    state_d    = state;
    lane_cnt_d = lane_cnt;
    wcnt_d     = wcnt;
    to_cnt_d   = '0;
    start      = 1'b0;
    wr         = 1'b0;
    clr        = 1'b0;
    close      = 1'b0;
    wr_lane    = lane_cnt;
    wr_idx     = wcnt;
    unique case (state)
      ST_IDLE: begin
        if (acc && in_sop) begin
          start = 1'b1;
        end else if (!acc && lane_cnt != 2'd0) begin
          if (to_cnt == TO_W'(TIMEOUT - 1)) state_d = ST_HOLD;
          else to_cnt_d = to_cnt + 1'b1;
        end
      end
      ST_FILL: begin
        if (acc) begin
          if (in_sop) begin
            // Implicit close; a new message cannot fit once lane 3 was open, so it is dropped.
            if (lane_cnt == 2'd2) state_d = ST_HOLD;
            else begin
              start   = 1'b1;
              wr_lane = lane_cnt + 2'd1;
            end
          end else begin
            wr    = 1'b1;
            close = in_eop;
            if (wcnt != IDX_W'(WORDS + 1)) wcnt_d = wcnt + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d    = ST_IDLE;
          lane_cnt_d = 2'd0;
          clr        = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      wr         = 1'b1;
      wr_idx     = '0;
      wcnt_d     = IDX_W'(1);
      lane_cnt_d = wr_lane;
      state_d    = ST_FILL;
      close      = in_eop;
    end
    if (close) begin
      if (wr_lane == 2'd2 || in_pkt_end) state_d = ST_HOLD;
      else begin
        state_d    = ST_IDLE;
        lane_cnt_d = wr_lane + 2'd1;
      end
    end
  end

  // State, counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lane_cnt   <= 2'd0;
      wcnt       <= '0;
      to_cnt     <= '0;
      in_ready   <= 1'b0;
      message_en <= 1'b0;
      trunc_err  <= 1'b0;
    end else begin
      state      <= state_d;
      lane_cnt   <= lane_cnt_d;
      wcnt       <= wcnt_d;
      to_cnt     <= to_cnt_d;
      in_ready   <= (state_d != ST_HOLD);
      message_en <= (state_d == ST_HOLD);
      trunc_err  <= |trunc_c;
    end
  end

  stage4_lane_buffer #(.DATA_W(DATA_W), .MSG_BITS(MSG_BITS), .CTRL_W(CTRL_W), .IDX_W(IDX_W)) u_lane1 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .start(start && wr_lane == 2'd0), .wr(wr && wr_lane == 2'd0),
    .idx(wr_idx), .data(in_data),
    .payload(message_1), .tag(message_mux_control_m1), .trunc_c(trunc_c[0])
  );

  stage4_lane_buffer #(.DATA_W(DATA_W), .MSG_BITS(MSG_BITS), .CTRL_W(CTRL_W), .IDX_W(IDX_W)) u_lane2 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .start(start && wr_lane == 2'd1), .wr(wr && wr_lane == 2'd1),
    .idx(wr_idx), .data(in_data),
    .payload(message_2), .tag(message_mux_control_m2), .trunc_c(trunc_c[1])
  );

  stage4_lane_buffer #(.DATA_W(DATA_W), .MSG_BITS(MSG_BITS), .CTRL_W(CTRL_W), .IDX_W(IDX_W)) u_lane3 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .start(start && wr_lane == 2'd2), .wr(wr && wr_lane == 2'd2),
    .idx(wr_idx), .data(in_data),
    .payload(message_3), .tag(message_mux_control_m3), .trunc_c(trunc_c[2])
  );

`ifdef STAGE4_MSG_CNT_EN
  logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] start_tag;
  assign start_tag = tag_decode(in_data[DATA_W-1 -: 8]);

  // Statistics: messages counted when they take a lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a     <= '0;
      cnt_k     <= '0;
      cnt_trunc <= '0;
    end else begin
      if (start && start_tag == MESSAGE_MUX_A) cnt_a <= cnt_a + 32'd1;
      if (start && start_tag == MESSAGE_MUX_K) cnt_k <= cnt_k + 32'd1;
      if (|trunc_c) cnt_trunc <= cnt_trunc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage4_message_assemble.sv
// Directed bench for stage4_message_assemble: batching, flush, timeout, truncation, hold, reset.
module tb_stage4_message_assemble;
  import stage4_message_assemble_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_sop, in_eop, in_pkt_end, out_ready;
  logic [63:0]  in_data;
  logic         message_en, trunc_err;
  logic [511:0] message_1, message_2, message_3;
  logic [1:0]   m1, m2, m3;
`ifdef STAGE4_MSG_CNT_EN
  logic [31:0]  cnt_a, cnt_k, cnt_trunc;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stage4_message_assemble dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_pkt_end(in_pkt_end),
    .out_ready(out_ready), .message_en(message_en),
    .message_1(message_1), .message_2(message_2), .message_3(message_3),
    .message_mux_control_m1(m1), .message_mux_control_m2(m2), .message_mux_control_m3(m3),
    .trunc_err(trunc_err)
`ifdef STAGE4_MSG_CNT_EN
    , .cnt_a(cnt_a), .cnt_k(cnt_k), .cnt_trunc(cnt_trunc)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic sop, input logic eop, input logic pend);
    in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop; in_pkt_end = pend;
    step();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_pkt_end = 1'b0;
  endtask

  logic [63:0]  t1 [6];
  logic [63:0]  w  [10];
  logic [511:0] e;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
    in_pkt_end = 1'b0; out_ready = 1'b1;
    t1[0] = 64'h61A1A1A1A1A1A1A1; t1[1] = 64'h1111111111111111;
    t1[2] = 64'h61B2B2B2B2B2B2B2; t1[3] = 64'h2222222222222222;
    t1[4] = 64'h61C3C3C3C3C3C3C3; t1[5] = 64'h3333333333333333;

    // Reset state
    repeat (2) step();
    chk("rst_in_ready", 512'(in_ready), 512'(1'b0));
    chk("rst_en", 512'(message_en), 512'(1'b0));
    chk("rst_msg1", message_1, 512'd0);
    chk("rst_tag1", 512'(m1), 512'(MESSAGE_MUX_NONE));
    chk("rst_trunc", 512'(trunc_err), 512'(1'b0));
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 512'(in_ready), 512'(1'b1));

    // Three 2-word 'a' messages fill a batch
    for (int i = 0; i < 6; i++) begin
      send(t1[i], (i % 2) == 0, (i % 2) == 1, 1'b0);
      if (i == 4) chk("t1_en_early", 512'(message_en), 512'(1'b0));
    end
    chk("t1_en", 512'(message_en), 512'(1'b1));
    chk("t1_in_ready", 512'(in_ready), 512'(1'b0));
    chk("t1_tag1", 512'(m1), 512'(MESSAGE_MUX_A));
    chk("t1_tag2", 512'(m2), 512'(MESSAGE_MUX_A));
    chk("t1_tag3", 512'(m3), 512'(MESSAGE_MUX_A));
    chk("t1_msg1", message_1, {t1[0], t1[1], 384'd0});
    chk("t1_msg2", message_2, {t1[2], t1[3], 384'd0});
    chk("t1_msg3", message_3, {t1[4], t1[5], 384'd0});
    step();
    chk("t1_en_drop", 512'(message_en), 512'(1'b0));
    chk("t1_ready_back", 512'(in_ready), 512'(1'b1));
    chk("t1_cleared", message_1, 512'd0);
    chk("t1_tag_cleared", 512'(m1), 512'(MESSAGE_MUX_NONE));

    // 'k' message ending the packet flushes a partial batch
    send(64'h6B01020304050607, 1'b1, 1'b0, 1'b0);
    send(64'h08090A0B0C0D0E0F, 1'b0, 1'b1, 1'b1);
    chk("t2_en", 512'(message_en), 512'(1'b1));
    chk("t2_tag1", 512'(m1), 512'(MESSAGE_MUX_K));
    chk("t2_tag2", 512'(m2), 512'(MESSAGE_MUX_NONE));
    chk("t2_tag3", 512'(m3), 512'(MESSAGE_MUX_NONE));
    chk("t2_msg1", message_1, {64'h6B01020304050607, 64'h08090A0B0C0D0E0F, 384'd0});
    chk("t2_msg2", message_2, 512'd0);
    chk("t2_msg3", message_3, 512'd0);
    step();
    chk("t2_en_drop", 512'(message_en), 512'(1'b0));

    // Timeout flush after 255 idle cycles
    send(64'h61DEADBEEF000001, 1'b1, 1'b1, 1'b0);
    repeat (254) step();
    chk("t3_en_254", 512'(message_en), 512'(1'b0));
    step();
    chk("t3_en_255", 512'(message_en), 512'(1'b1));
    chk("t3_tag1", 512'(m1), 512'(MESSAGE_MUX_A));
    chk("t3_msg1", message_1, {64'h61DEADBEEF000001, 448'd0});
    step();
    chk("t3_en_drop", 512'(message_en), 512'(1'b0));

    // 254 idle cycles then a new sop: no flush
    send(64'h61000000000000AA, 1'b1, 1'b1, 1'b0);
    repeat (254) step();
    send(64'h6B000000000000BB, 1'b1, 1'b0, 1'b0);
    chk("t3b_no_flush", 512'(message_en), 512'(1'b0));
    step();
    chk("t3b_still_open", 512'(message_en), 512'(1'b0));
    send(64'h00000000000000CC, 1'b0, 1'b1, 1'b1);
    chk("t3b_en", 512'(message_en), 512'(1'b1));
    chk("t3b_tag1", 512'(m1), 512'(MESSAGE_MUX_A));
    chk("t3b_tag2", 512'(m2), 512'(MESSAGE_MUX_K));
    chk("t3b_tag3", 512'(m3), 512'(MESSAGE_MUX_NONE));
    chk("t3b_msg2", message_2, {64'h6B000000000000BB, 64'h00000000000000CC, 384'd0});
    step();

    // 10-word message truncated to 8 words, single trunc_err pulse
    for (int j = 0; j < 10; j++) w[j] = (j == 0) ? 64'h6100000000000000 : 64'hF000000000000000 + 64'(j);
    for (int j = 0; j < 10; j++) begin
      send(w[j], j == 0, j == 9, j == 9);
      chk($sformatf("t4_trunc_w%0d", j), 512'(trunc_err), 512'(j == 8));
    end
    e = '0;
    for (int k = 0; k < 8; k++) e[511-64*k -: 64] = w[k];
    chk("t4_en", 512'(message_en), 512'(1'b1));
    chk("t4_msg1", message_1, e);
    step();

    // HOLD stalls while out_ready is low
    out_ready = 1'b0;
    send(64'h6B55555555555555, 1'b1, 1'b1, 1'b1);
    chk("t5_en", 512'(message_en), 512'(1'b1));
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t5_hold_en", 512'(message_en), 512'(1'b1));
      chk("t5_hold_ready", 512'(in_ready), 512'(1'b0));
      chk("t5_hold_msg1", message_1, {64'h6B55555555555555, 448'd0});
    end
    out_ready = 1'b1;
    step();
    chk("t5_release_en", 512'(message_en), 512'(1'b0));
    chk("t5_release_ready", 512'(in_ready), 512'(1'b1));
    chk("t5_release_msg1", message_1, 512'd0);

    // Reset mid-message discards the partial batch
    send(64'h61EEEEEEEEEEEEEE, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en", 512'(message_en), 512'(1'b0));
    chk("t6_rst_msg1", message_1, 512'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_ready", 512'(in_ready), 512'(1'b1));
    send(64'h6101010101010101, 1'b1, 1'b1, 1'b0);
    chk("t6_en_1", 512'(message_en), 512'(1'b0));
    send(64'h6B02020202020202, 1'b1, 1'b1, 1'b0);
    chk("t6_en_2", 512'(message_en), 512'(1'b0));
    send(64'h7A03030303030303, 1'b1, 1'b1, 1'b0);
    chk("t6_en", 512'(message_en), 512'(1'b1));
    chk("t6_tag1", 512'(m1), 512'(MESSAGE_MUX_A));
    chk("t6_tag2", 512'(m2), 512'(MESSAGE_MUX_K));
    chk("t6_tag3", 512'(m3), 512'(MESSAGE_MUX_NONE));
    chk("t6_msg1", message_1, {64'h6101010101010101, 448'd0});
    chk("t6_msg3", message_3, {64'h7A03030303030303, 448'd0});
    step();
    chk("t6_en_drop", 512'(message_en), 512'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
